// File: rtl/seven_seg_capture_if.sv
// ----------------------------------------------------------------------------
// seven_seg_capture_if
//   Groups the multiplexed display bus and the frame handshake that surround
//   the seven-segment capture block.
//
//   master : the display/scoreboard side. It drives the segment/anode bus,
//            frame_ready and clr_err, and observes the frame and error outputs.
//   slave  : the capture block itself.
//
//   seg_n        segment bus, active-low, bit0=a .. bit6=g
//   an_n         digit enables, active-low, one-cold when valid
//   frame_data   digit i in [4i+3:4i]; 0-9, 4'hF=blank, 4'hE=illegal
//   frame_valid  frame_data holds an unaccepted frame
//   frame_ready  consumer accepts when frame_valid && frame_ready
//   err_illegal  sticky: a non-digit, non-blank pattern was captured
//   err_overrun  sticky: a frame completed while the previous one was pending
//   clr_err      synchronous clear of both sticky error flags
// ----------------------------------------------------------------------------
interface seven_seg_capture_if #(
  parameter int NDIG = 4
);
  logic [6:0]        seg_n;
  logic [NDIG-1:0]   an_n;
  logic [4*NDIG-1:0] frame_data;
  logic              frame_valid;
  logic              frame_ready;
  logic              err_illegal;
  logic              err_overrun;
  logic              clr_err;

  modport master (
    output seg_n, an_n, frame_ready, clr_err,
    input  frame_data, frame_valid, err_illegal, err_overrun
  );

  modport slave (
    input  seg_n, an_n, frame_ready, clr_err,
    output frame_data, frame_valid, err_illegal, err_overrun
  );
endinterface

// File: rtl/seven_seg_capture.sv
// ----------------------------------------------------------------------------
// seven_seg_capture
//   Receive-side partner of the BCD-to-7-segment driver. Samples the
//   multiplexed active-low segment/anode bus, waits for each pattern to be
//   stable, decodes the digit shown on the active position and, once every
//   position has been seen, offers the whole frame on a valid/ready handshake.
//
//   Ports:
//     clk      system clock
//     reset_n  asynchronous active-low reset
//     bus      seven_seg_capture_if.slave (display bus, frame handshake,
//              sticky error flags and their clear)
//
//   Parameters:
//     NDIG           number of multiplexed digit positions (1..8)
//     STABLE_CYCLES  consecutive identical synced samples needed to accept
//     CNT_W          width of the stability counter (must hold STABLE_CYCLES)
// ----------------------------------------------------------------------------
module seven_seg_capture #(
  parameter int NDIG          = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  seven_seg_capture_if.slave bus
);

  localparam int SW    = NDIG + 7;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HELD
  } state_t;

  // Active-low seven-segment pattern to BCD; blank and illegal get codes.
  function automatic logic [3:0] decode(input logic [6:0] seg);
    logic [3:0] code;
    case (seg)
      7'h40:   code = 4'd0;
      7'h79:   code = 4'd1;
      7'h24:   code = 4'd2;
      7'h30:   code = 4'd3;
      7'h19:   code = 4'd4;
      7'h12:   code = 4'd5;
      7'h02:   code = 4'd6;
      7'h78:   code = 4'd7;
      7'h00:   code = 4'd8;
      7'h18:   code = 4'd9;
      7'h7F:   code = 4'hF;
      default: code = 4'hE;
    endcase
    return code;
  endfunction

  // --------------------------------------------------------------------------
  // Input synchroniser: sync_q/s form the 2-flop synchroniser, s_d is the
  // previous synced sample used for the stability comparison.
  // --------------------------------------------------------------------------
  logic [SW-1:0] sync_q;
  logic [SW-1:0] s;
  logic [SW-1:0] s_d;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop in the chain samples the value from before the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      s      <= '0;
      s_d    <= '0;
    end else begin
      sync_q <= {bus.an_n, bus.seg_n};
      s      <= sync_q;
      s_d    <= s;
    end
  end

  logic [NDIG-1:0] s_an;
  logic [6:0]      s_seg;
  logic            changed;

  assign s_an    = s[SW-1:7];
  assign s_seg   = s[6:0];
  assign changed = (s != s_d);

  // --------------------------------------------------------------------------
  // Anode decode: exactly one low enable selects a position.
  // --------------------------------------------------------------------------
  logic [3:0]       zero_cnt;
  logic [IDX_W-1:0] idx;
  logic             an_ok;

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    zero_cnt = '0;
    idx      = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (!s_an[i]) begin
        zero_cnt = zero_cnt + 4'd1;
        idx      = IDX_W'(i);
      end
    end
    an_ok = (zero_cnt == 4'd1);
  end

  // --------------------------------------------------------------------------
  // Stability FSM
  // --------------------------------------------------------------------------
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             capture;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    capture = 1'b0;
    unique case (state)
      IDLE: begin
        if (an_ok) begin
          state_n = SETTLE;
          cnt_n   = '0;
        end
      end
      SETTLE: begin
        if (!an_ok) begin
          state_n = IDLE;
        end else if (changed) begin
          cnt_n = '0;
        end else if (cnt == CNT_LAST) begin
          capture = 1'b1;
          state_n = HELD;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!an_ok) begin
          state_n = IDLE;
        end else if (changed) begin
          state_n = SETTLE;
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Capture datapath: shadow digits, seen mask, frame completion
  // --------------------------------------------------------------------------
  logic [NDIG-1:0][3:0] shadow, shadow_n;
  logic [NDIG-1:0]      seen, seen_n;
  logic [3:0]           code;
  logic                 complete;

  always_comb begin
    code     = decode(s_seg);
    shadow_n = shadow;
    seen_n   = seen;
    if (capture) begin
      shadow_n[idx] = code;
      seen_n[idx]   = 1'b1;
    end
    // The mask tested includes this edge's capture.
    complete = capture && (&seen_n);
  end

  logic [4*NDIG-1:0] frame_data_q;
  logic              frame_valid_q;
  logic              err_illegal_q;
  logic              err_overrun_q;
  logic              accept;
  logic              drop;

  assign accept = frame_valid_q && bus.frame_ready;
  // Completion while the pending frame is not taken this edge loses the new one.
  assign drop   = complete && frame_valid_q && !bus.frame_ready;

  // NOTE: the shadow digit store is small, so it is reset like all other state
  // and frame_data never exposes X after a partial scan.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow        <= '0;
      seen          <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      err_illegal_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      shadow <= shadow_n;
      seen   <= complete ? '0 : seen_n;

      if (complete && !drop) begin
        frame_data_q  <= shadow_n;
        frame_valid_q <= 1'b1;
      end else if (accept) begin
        frame_valid_q <= 1'b0;
      end

      // Setting a flag wins over clearing it on the same edge.
      if (capture && (code == 4'hE)) begin
        err_illegal_q <= 1'b1;
      end else if (bus.clr_err) begin
        err_illegal_q <= 1'b0;
      end

      if (drop) begin
        err_overrun_q <= 1'b1;
      end else if (bus.clr_err) begin
        err_overrun_q <= 1'b0;
      end
    end
  end

  assign bus.frame_data  = frame_data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.err_illegal = err_illegal_q;
  assign bus.err_overrun = err_overrun_q;

endmodule
